upd7800_bus_responder: RTL

- Bus-responder peripheral for the uPD7800 core: the memory-side end of the CPU bus.
- Decodes A, serves reads from an internal work RAM and a small register bank, and commits CPU writes.
- Counts opcode fetches (M1) for bring-up and bench checks.
- Sits beside the boot ROM on the CPU bus; the top-level DB_I mux selects DB_O when nCS is low.

---
 rtl/upd7800_bus_pkg.sv | 25 ++
 rtl/upd7800_bus_ram.sv | 25 ++
 rtl/upd7800_bus_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/upd7800_bus_pkg.sv
// Shared types and register-bank offsets for the uPD7800 bus responder.
// The trace offsets are only decoded when UPD7800_BUS_TRACE_EN is defined.
package upd7800_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } bus_state_e;

  localparam logic [2:0] REG_M1LO    = 3'd0;
  localparam logic [2:0] REG_M1HI    = 3'd1;
  localparam logic [2:0] REG_SCRATCH = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_TRLO    = 3'd4;
  localparam logic [2:0] REG_TRHI    = 3'd5;

  // True when addr falls in the 2**aw-byte window starting at an aligned base.
  function automatic logic addr_in_window(input logic [15:0] addr,
                                          input logic [15:0] base,
                                          input int unsigned aw);
    return ((addr ^ base) >> aw) == 16'd0;
  endfunction

endpackage

// File: rtl/upd7800_bus_ram.sv
// Single-port synchronous work RAM, 2**RAM_AW x 8, registered read data.
module upd7800_bus_ram #(
  parameter int RAM_AW = 11
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [RAM_AW-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem [2**RAM_AW];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem[addr_i] <= wdata_i;
      else      rdata_q     <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/upd7800_bus_responder.sv
// Memory-side end of the uPD7800 CPU bus: work RAM, register bank, M1 counter.
// Define UPD7800_BUS_TRACE_EN to add the last-M1-address trace registers (offsets 4/5).
module upd7800_bus_responder
  import upd7800_bus_pkg::*;
#(
  parameter logic [15:0] RAM_BASE = 16'h2000,
  parameter int          RAM_AW   = 11,
  parameter logic [15:0] REG_BASE = 16'h3000
) (
  input  logic        CLK,
  input  logic        RESETB,
  input  logic        CP1_POSEDGE,
  input  logic        CP2_NEGEDGE,
  input  logic [15:0] A,
  input  logic        RDB,
  input  logic        WRB,
  input  logic        M1,
  input  logic [7:0]  DB_I,
  input  logic        DB_OE,
  output logic [7:0]  DB_O,
  output logic        nCS
);

  bus_state_e        state_q;
  logic [RAM_AW-1:0] addr_q;
  logic              is_ram_q;
  logic              rd_pend_q;
  logic              wr_done_q;
  logic [7:0]        dbo_q;
  logic              ncs_q;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        shadow_q;
  logic              err_q, err_d;
  logic [7:0]        scratch_q;

  logic              ram_hit, reg_hit, hit;
  logic              cp1_hit_idle, rd_start, wr_start, commit, m1_inc, clr;
  logic [2:0]        reg_off;
  logic [7:0]        reg_rdata;
  logic              ram_en, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_rdata;

  assign ram_hit = addr_in_window(A, RAM_BASE, RAM_AW);
`ifdef UPD7800_BUS_TRACE_EN
  logic [15:0] trace_q;
  assign reg_hit = addr_in_window(A, REG_BASE, 3) && (A[2:0] <= REG_TRHI);
  assign reg_off = addr_q[2:0];
`else
  assign reg_hit = addr_in_window(A, REG_BASE, 2);
  assign reg_off = {1'b0, addr_q[1:0]};
`endif
  assign hit = ram_hit | reg_hit;

  assign cp1_hit_idle = (state_q == IDLE) && CP1_POSEDGE && hit;
  assign rd_start     = cp1_hit_idle && !RDB && WRB;
  assign wr_start     = cp1_hit_idle && RDB && !WRB;
  // Only the first data phase of a write cycle is committed.
  assign commit       = (state_q == WR) && CP2_NEGEDGE && DB_OE && !wr_done_q;
  assign m1_inc       = CP1_POSEDGE && M1 && !RDB;
  assign clr          = commit && !is_ram_q &&
                        (reg_off == REG_M1LO || reg_off == REG_M1HI || reg_off == REG_STATUS);

  // A clearing write beats a simultaneous fetch increment.
  assign cnt_d = clr ? 16'h0000 : (m1_inc ? cnt_q + 16'd1 : cnt_q);
  assign err_d = clr ? 1'b0 : ((cp1_hit_idle && !RDB && !WRB) ? 1'b1 : err_q);

  // Reads start the RAM on the entry edge so data is ready one CLK later.
  assign ram_en   = (rd_start && ram_hit) || (commit && is_ram_q);
  assign ram_we   = commit && is_ram_q;
  assign ram_addr = commit ? addr_q : A[RAM_AW-1:0];

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_off)
      REG_M1LO:    reg_rdata = cnt_q[7:0];
      REG_M1HI:    reg_rdata = shadow_q;
      REG_SCRATCH: reg_rdata = scratch_q;
      REG_STATUS:  reg_rdata = {7'b0, err_q};
`ifdef UPD7800_BUS_TRACE_EN
      REG_TRLO:    reg_rdata = trace_q[7:0];
      REG_TRHI:    reg_rdata = trace_q[15:8];
`endif
      default:     reg_rdata = 8'h00;
    endcase
  end

  upd7800_bus_ram #(.RAM_AW(RAM_AW)) u_ram (
    .clk_i   (CLK),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (DB_I),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      is_ram_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_done_q <= 1'b0;
      dbo_q     <= 8'h00;
      ncs_q     <= 1'b1;
      cnt_q     <= 16'h0000;
      shadow_q  <= 8'h00;
      err_q     <= 1'b0;
      scratch_q <= 8'h00;
    end else begin
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rd_pend_q <= 1'b0;
      if (rd_pend_q) begin
        dbo_q <= is_ram_q ? ram_rdata : reg_rdata;
        // Snapshot the high byte so a later offset-1 read pairs with this low byte.
        if (!is_ram_q && reg_off == REG_M1LO) shadow_q <= cnt_q[15:8];
      end
      if (commit) begin
        wr_done_q <= 1'b1;
        if (!is_ram_q && reg_off == REG_SCRATCH) scratch_q <= DB_I;
      end
      case (state_q)
        IDLE: if (rd_start || wr_start) begin
          addr_q    <= A[RAM_AW-1:0];
          is_ram_q  <= ram_hit;
          wr_done_q <= 1'b0;
          rd_pend_q <= rd_start;
          ncs_q     <= !rd_start;
          state_q   <= rd_start ? RD : WR;
        end
        RD: if (CP1_POSEDGE && RDB) begin
          ncs_q   <= 1'b1;
          state_q <= IDLE;
        end
        WR: if (CP1_POSEDGE && WRB) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UPD7800_BUS_TRACE_EN
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB)     trace_q <= 16'h0000;
    else if (m1_inc) trace_q <= A;
  end
`endif

  assign DB_O = dbo_q;
  assign nCS  = ncs_q;

endmodule
